// File: rtl/greenhouse_display_pkg.sv
// greenhouse_display_pkg
//   Shared types and constants for the greenhouse VGA status display path:
//   BCD temperature word layout, set-point limit defaults, button FSM states,
//   and small BCD helper functions.
//   BCD word: [9:8]=hundreds, [7:4]=tens, [3:0]=ones.
package greenhouse_display_pkg;

   localparam int HUND       = 2;
   localparam int TENS       = 4;
   localparam int ONES       = 4;
   localparam int TEMP_BCD_W = HUND + TENS + ONES;
   localparam int ONES_LSB   = 0;
   localparam int TENS_LSB   = ONES_LSB + ONES;
   localparam int HUND_LSB   = TENS_LSB + TENS;

   // Limits shared with display_controller (decimal degrees F)
   localparam int unsigned SET_MIN_DEF     = 40;
   localparam int unsigned SET_MAX_DEF     = 100;
   localparam int unsigned SET_DEFAULT_DEF = 70;

   typedef struct packed {
      logic [HUND-1:0] hund;
      logic [TENS-1:0] tens;
      logic [ONES-1:0] ones;
   } bcd_temp_t;

   typedef enum logic [1:0] {
      BTN_IDLE   = 2'd0,
      BTN_HELD   = 2'd1,
      BTN_REPEAT = 2'd2
   } btn_state_e;

   // Decimal constant to BCD word (elaboration-time use only)
   function automatic bcd_temp_t to_bcd(input int unsigned v);
      bcd_temp_t b;
      b.hund = HUND'((v / 100) % 4);
      b.tens = TENS'((v / 10) % 10);
      b.ones = ONES'(v % 10);
      return b;
   endfunction

   function automatic bcd_temp_t bcd_inc(input bcd_temp_t a);
      bcd_temp_t r;
      r = a;
      if (a.ones == 4'd9) begin
         r.ones = '0;
         if (a.tens == 4'd9) begin
            r.tens = '0;
            r.hund = a.hund + 2'd1;
         end else begin
            r.tens = a.tens + 4'd1;
         end
      end else begin
         r.ones = a.ones + 4'd1;
      end
      return r;
   endfunction

   function automatic bcd_temp_t bcd_dec(input bcd_temp_t a);
      bcd_temp_t r;
      r = a;
      if (a.ones == 4'd0) begin
         r.ones = 4'd9;
         if (a.tens == 4'd0) begin
            r.tens = 4'd9;
            r.hund = a.hund - 2'd1;
         end else begin
            r.tens = a.tens - 4'd1;
         end
      end else begin
         r.ones = a.ones - 4'd1;
      end
      return r;
   endfunction

   // The 2-bit hundreds field cannot exceed 3, so only tens/ones need checking.
   function automatic logic bcd_valid(input bcd_temp_t a);
      return (a.tens <= 4'd9) && (a.ones <= 4'd9);
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner
//   One pushbutton: 2-FF synchronizer, debounce, and IDLE/HELD/REPEAT
//   stepping FSM.
//   Ports:
//     clk_i       system clock
//     rst_i       synchronous active-high reset
//     key_n_i     raw button, active-low, asynchronous
//     pressed_o   debounced level, 1 = pressed
//     step_pulse  one-cycle step request
module button_conditioner
   import greenhouse_display_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic pressed_o,
   output logic step_pulse
);

   localparam int unsigned TM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TM_W = $clog2(TM_MAX + 1);

   logic [1:0]      sync_q;
   logic            raw_press;
   logic            deb_q, deb_d, deb_prev_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   btn_state_e      state_q, state_d;
   logic [TM_W-1:0] tm_cnt_q, tm_cnt_d;
   logic            press_edge;

   assign raw_press = ~sync_q[1];
   assign pressed_o = deb_q;
   assign press_edge = deb_q & ~deb_prev_q;

   // Count consecutive samples that disagree with the debounced level; any
   // agreeing sample restarts the count. The Nth disagreeing sample is accepted.
   always_comb begin
      db_cnt_d = '0;
      deb_d    = deb_q;
      if (raw_press != deb_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d = raw_press;
         else                                       db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      tm_cnt_d   = tm_cnt_q;
      step_pulse = 1'b0;
      case (state_q)
         BTN_IDLE: begin
            tm_cnt_d = '0;
            if (press_edge) begin
               step_pulse = 1'b1;
               state_d    = BTN_HELD;
            end
         end
         BTN_HELD: begin
            if (!deb_q) begin
               state_d  = BTN_IDLE;
               tm_cnt_d = '0;
            end else if (tm_cnt_q == TM_W'(HOLD_CYCLES - 1)) begin
               step_pulse = 1'b1;
               state_d    = BTN_REPEAT;
               tm_cnt_d   = '0;
            end else begin
               tm_cnt_d = tm_cnt_q + 1'b1;
            end
         end
         BTN_REPEAT: begin
            if (!deb_q) begin
               state_d  = BTN_IDLE;
               tm_cnt_d = '0;
            end else if (tm_cnt_q == TM_W'(REPEAT_CYCLES - 1)) begin
               step_pulse = 1'b1;
               tm_cnt_d   = '0;
            end else begin
               tm_cnt_d = tm_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = BTN_IDLE;
            tm_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q     <= 2'b11;   // released level
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         db_cnt_q   <= '0;
         state_q    <= BTN_IDLE;
         tm_cnt_q   <= '0;
      end else begin
         sync_q     <= {sync_q[0], key_n_i};
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         tm_cnt_q   <= tm_cnt_d;
      end
   end

endmodule

// File: rtl/set_temp_controller.sv
// set_temp_controller
//   Set-point entry from two buttons plus frame-synchronous latching of the
//   set-point and actual temperature for the VGA digit renderers.
//   Ports:
//     CLOCK_50      system clock
//     reset         synchronous active-high reset
//     KEY_UP_N      raise button, active-low, async
//     KEY_DOWN_N    lower button, active-low, async
//     VGA_VS        vertical sync, active-low, foreign clock domain
//     TEMP_F_IN     actual temperature, BCD (quasi-static)
//     SET_TEMP_BCD  displayed set-point, BCD, changes only at vsync start
//     TEMP_F_DISP   displayed actual temperature, BCD, changes only at vsync start
//     SET_CHANGED   one-cycle pulse after a latch that changed SET_TEMP_BCD
module set_temp_controller
   import greenhouse_display_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000,
   parameter int unsigned SET_MIN         = SET_MIN_DEF,
   parameter int unsigned SET_MAX         = SET_MAX_DEF,
   parameter int unsigned SET_DEFAULT     = SET_DEFAULT_DEF
)(
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  KEY_UP_N,
   input  logic                  KEY_DOWN_N,
   input  logic                  VGA_VS,
   input  logic [TEMP_BCD_W-1:0] TEMP_F_IN,
   output logic [TEMP_BCD_W-1:0] SET_TEMP_BCD,
   output logic [TEMP_BCD_W-1:0] TEMP_F_DISP,
   output logic                  SET_CHANGED
);

   localparam bcd_temp_t MIN_BCD = to_bcd(SET_MIN);
   localparam bcd_temp_t MAX_BCD = to_bcd(SET_MAX);
   localparam bcd_temp_t DEF_BCD = to_bcd(SET_DEFAULT);

   logic up_pressed, up_step, dn_pressed, dn_step;
   logic do_up, do_dn;

   bcd_temp_t set_work_q, set_work_d;
   logic [1:0] vs_sync_q;
   logic       vs_dly_q, vs_fall;
   logic [TEMP_BCD_W-1:0] set_disp_q, set_disp_d, temp_disp_q, temp_disp_d;
   logic       set_chg_q, set_chg_d;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_btn_up (
      .clk_i      (CLOCK_50),
      .rst_i      (reset),
      .key_n_i    (KEY_UP_N),
      .pressed_o  (up_pressed),
      .step_pulse (up_step)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_btn_dn (
      .clk_i      (CLOCK_50),
      .rst_i      (reset),
      .key_n_i    (KEY_DOWN_N),
      .pressed_o  (dn_pressed),
      .step_pulse (dn_step)
   );

   // Both held suppresses everything; simultaneous opposite steps cancel.
   assign do_up = up_step & ~dn_step & ~(up_pressed & dn_pressed);
   assign do_dn = dn_step & ~up_step & ~(up_pressed & dn_pressed);

   // Valid BCD words order the same as their decimal values, so a plain
   // vector compare implements the saturation limits.
   always_comb begin
      set_work_d = set_work_q;
      if (do_up && (TEMP_BCD_W'(set_work_q) < TEMP_BCD_W'(MAX_BCD)))
         set_work_d = bcd_inc(set_work_q);
      else if (do_dn && (TEMP_BCD_W'(set_work_q) > TEMP_BCD_W'(MIN_BCD)))
         set_work_d = bcd_dec(set_work_q);
   end

   assign vs_fall = vs_dly_q & ~vs_sync_q[1];

   always_comb begin
      set_disp_d  = set_disp_q;
      temp_disp_d = temp_disp_q;
      set_chg_d   = 1'b0;
      if (vs_fall) begin
         set_disp_d = set_work_q;
         set_chg_d  = (TEMP_BCD_W'(set_work_q) != set_disp_q);
         if (bcd_valid(bcd_temp_t'(TEMP_F_IN))) temp_disp_d = TEMP_F_IN;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         set_work_q  <= DEF_BCD;
         vs_sync_q   <= 2'b11;
         vs_dly_q    <= 1'b1;
         set_disp_q  <= TEMP_BCD_W'(DEF_BCD);
         temp_disp_q <= '0;
         set_chg_q   <= 1'b0;
      end else begin
         set_work_q  <= set_work_d;
         vs_sync_q   <= {vs_sync_q[0], VGA_VS};
         vs_dly_q    <= vs_sync_q[1];
         set_disp_q  <= set_disp_d;
         temp_disp_q <= temp_disp_d;
         set_chg_q   <= set_chg_d;
      end
   end

   assign SET_TEMP_BCD = set_disp_q;
   assign TEMP_F_DISP  = temp_disp_q;
   assign SET_CHANGED  = set_chg_q;

endmodule

// File: tb/tb_set_temp_controller.sv
module tb_set_temp_controller;

   logic       CLOCK_50   = 1'b0;
   logic       reset      = 1'b1;
   logic       KEY_UP_N   = 1'b1;
   logic       KEY_DOWN_N = 1'b1;
   logic       VGA_VS     = 1'b1;
   logic [9:0] TEMP_F_IN  = 10'h072;
   logic [9:0] SET_TEMP_BCD, TEMP_F_DISP;
   logic       SET_CHANGED;

   always #5 CLOCK_50 = ~CLOCK_50;

   set_temp_controller #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (20),
      .REPEAT_CYCLES   (5)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .KEY_UP_N     (KEY_UP_N),
      .KEY_DOWN_N   (KEY_DOWN_N),
      .VGA_VS       (VGA_VS),
      .TEMP_F_IN    (TEMP_F_IN),
      .SET_TEMP_BCD (SET_TEMP_BCD),
      .TEMP_F_DISP  (TEMP_F_DISP),
      .SET_CHANGED  (SET_CHANGED)
   );

   typedef struct {
      logic [9:0] set;
      logic [9:0] temp;
      bit         chg;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0, n_pass = 0;
   int   exp_val = 70;             // model set-point, plain decimal
   logic [9:0] disp_set  = 10'h070;
   logic [9:0] disp_temp = 10'h000;
   int   chg_exp_tot = 0, chg_seen_tot = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [9:0] dec2bcd(input int v);
      return 10'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
   endfunction

   function automatic bit temp_ok(input logic [9:0] t);
      return (t[7:4] <= 4'd9) && (t[3:0] <= 4'd9);
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // Short press: debounced, well under the hold time, then fully released.
   task automatic press(input bit up, input int n_low);
      if (up) KEY_UP_N = 1'b0; else KEY_DOWN_N = 1'b0;
      cycles(n_low);
      KEY_UP_N = 1'b1; KEY_DOWN_N = 1'b1;
      cycles(12);
   endtask

   task automatic tap(input bit up, input int n);
      for (int i = 0; i < n; i++) begin
         press(up, 10);
         if (up) exp_val = (exp_val < 100) ? exp_val + 1 : 100;
         else    exp_val = (exp_val > 40)  ? exp_val - 1 : 40;
      end
   endtask

   // One frame: predict the latch result, then pulse VS low.
   task automatic frame();
      exp_t e;
      e.set  = dec2bcd(exp_val);
      e.temp = temp_ok(TEMP_F_IN) ? TEMP_F_IN : disp_temp;
      e.chg  = (e.set != disp_set);
      disp_set  = e.set;
      disp_temp = e.temp;
      if (e.chg) chg_exp_tot++;
      sb_q.push_back(e);
      VGA_VS = 1'b0;
      cycles(4);
      VGA_VS = 1'b1;
      cycles(196);
   endtask

   // Frame output monitor: pops the prediction after the latch has settled.
   initial begin : mon
      int   hi;
      exp_t e;
      forever begin
         @(negedge VGA_VS);
         hi = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            if (SET_CHANGED === 1'b1) hi++;
         end
         if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb_q.pop_front();
            chk("frame_set",  SET_TEMP_BCD, e.set);
            chk("frame_temp", TEMP_F_DISP,  e.temp);
            chk("frame_chg",  hi,           e.chg);
         end
      end
   end

   always @(negedge CLOCK_50) if (SET_CHANGED === 1'b1) chg_seen_tot++;

   initial begin
      cycles(5);
      chk("rst_set",  SET_TEMP_BCD, 10'h070);
      chk("rst_temp", TEMP_F_DISP,  10'h000);
      chk("rst_chg",  SET_CHANGED,  1'b0);
      reset = 1'b0;
      cycles(10);

      // 1: first frame after reset
      frame();

      // 2: short glitches, then a real press -> one step
      KEY_UP_N = 1'b0; cycles(2); KEY_UP_N = 1'b1; cycles(2);
      KEY_UP_N = 1'b0; cycles(2); KEY_UP_N = 1'b1; cycles(2);
      tap(1'b1, 1);
      frame();
      KEY_UP_N = 1'b0; cycles(3); KEY_UP_N = 1'b1; cycles(12);
      frame();

      // 3: BCD borrow/carry around 69/70, then hold-and-repeat
      tap(1'b0, 2);  frame();
      tap(1'b1, 1);  frame();
      tap(1'b0, 1);  frame();
      // 40 debounced cycles: press, hold expiry (+20), repeats at +25/+30/+35
      press(1'b1, 40);
      exp_val = exp_val + 5;
      frame();

      // 4: saturation at both limits
      tap(1'b1, 25); frame();
      tap(1'b1, 1);  frame();
      tap(1'b1, 2);  frame();
      tap(1'b0, 59); frame();
      tap(1'b0, 1);  frame();
      tap(1'b0, 2);  frame();

      // 5: both keys together -> nothing
      KEY_UP_N = 1'b0; KEY_DOWN_N = 1'b0;
      cycles(50);
      KEY_UP_N = 1'b1; KEY_DOWN_N = 1'b1;
      cycles(20);
      frame();

      // 6: invalid temperatures hold, valid ones latch only at vsync
      TEMP_F_IN = 10'h07A; frame();
      TEMP_F_IN = 10'h085; cycles(5);
      chk("temp_between_frames", TEMP_F_DISP, disp_temp);
      frame();
      TEMP_F_IN = 10'h0A5; frame();
      TEMP_F_IN = 10'h105; frame();

      // Reset while auto-repeating; key stays down through reset
      KEY_UP_N = 1'b0;
      cycles(35);
      reset = 1'b1;
      @(posedge CLOCK_50); #1;
      chk("midrep_rst_set",  SET_TEMP_BCD, 10'h070);
      chk("midrep_rst_temp", TEMP_F_DISP,  10'h000);
      chk("midrep_rst_chg",  SET_CHANGED,  1'b0);
      @(negedge CLOCK_50);
      cycles(3);
      exp_val = 70; disp_set = 10'h070; disp_temp = 10'h000;
      reset = 1'b0;
      cycles(10);
      KEY_UP_N = 1'b1;
      cycles(12);
      exp_val = 71;
      frame();

      chk("chg_pulse_total", chg_seen_tot, chg_exp_tot);
      chk("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
